// File: rtl/lc3_mem_responder.sv
// LC-3 memory-side responder: answers the control FSM's MAR/MDR/MEM.EN/R.W
// handshake with fixed-latency RAM and the memory-mapped device registers
// (KBSR/KBDR, DSR/DDR, MCR).
module lc3_mem_responder #(
  parameter int MEM_WORDS = 65536,
  parameter int LATENCY   = 2,
  parameter int DISP_BUSY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [15:0] mar,
  input  logic [15:0] mdr,
  output logic [15:0] rdata,
  output logic        mem_r,
  input  logic        kb_valid,
  input  logic [7:0]  kb_char,
  output logic        disp_valid,
  output logic [7:0]  disp_char,
  output logic        halted
);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int BW = $clog2(DISP_BUSY + 1);

  localparam logic [15:0] A_KBSR = 16'hFE00;
  localparam logic [15:0] A_KBDR = 16'hFE02;
  localparam logic [15:0] A_DSR  = 16'hFE04;
  localparam logic [15:0] A_DDR  = 16'hFE06;
  localparam logic [15:0] A_MCR  = 16'hFFFE;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nx;
  logic [3:0]      lat_cnt;
  logic [15:0]     req_addr, req_data;
  logic            req_we;
  logic [15:0]     ram [MEM_WORDS];

  logic            kb_ready;
  logic [7:0]      kb_data;
  logic            dsr_ready;
  logic [BW-1:0]   busy_cnt;
  logic            mcr_run;

  // With LATENCY=1 the read value is captured straight out of IDLE, before
  // the request registers are loaded, so decode from the live address then.
  logic [15:0]     acc_addr;
  logic            acc_mmio, acc_in_ram;
  logic [15:0]     rd_val;
  logic            commit, kbdr_clr;
  logic            req_mmio, req_in_ram;

  assign acc_addr   = (state == IDLE) ? mar : req_addr;
  assign acc_mmio   = (acc_addr == A_KBSR) || (acc_addr == A_KBDR) || (acc_addr == A_DSR) ||
                      (acc_addr == A_DDR)  || (acc_addr == A_MCR);
  assign acc_in_ram = !acc_mmio && ({1'b0, acc_addr} < 17'(MEM_WORDS));

  assign req_mmio   = (req_addr == A_KBSR) || (req_addr == A_KBDR) || (req_addr == A_DSR) ||
                      (req_addr == A_DDR)  || (req_addr == A_MCR);
  assign req_in_ram = !req_mmio && ({1'b0, req_addr} < 17'(MEM_WORDS));

  // Side effects land on the edge that leaves RESP.
  assign commit   = (state == RESP);
  assign kbdr_clr = commit && !req_we && (req_addr == A_KBDR);
  assign halted   = ~mcr_run;

  // Read mux: device registers by exact match, otherwise RAM (0 past the end).
  always_comb begin
    rd_val = '0;
    case (acc_addr)
      A_KBSR:  rd_val = {kb_ready, 15'b0};
      A_KBDR:  rd_val = {8'b0, kb_data};
      A_DSR:   rd_val = {dsr_ready, 15'b0};
      A_DDR:   rd_val = '0;
      A_MCR:   rd_val = {mcr_run, 15'b0};
      default: if (acc_in_ram) rd_val = ram[acc_addr[AW-1:0]];
    endcase
  end

  // Handshake next-state: accept in IDLE, count down latency, pulse R once.
  always_comb begin
    state_nx = state;
    mem_r    = 1'b0;
    case (state)
      IDLE: if (mem_en) state_nx = (LATENCY <= 1) ? RESP : WAIT;
      WAIT: if (lat_cnt <= 4'd1) state_nx = RESP;
      RESP: begin
        mem_r    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register, latency counter, request latch and response data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      lat_cnt <= '0;
      rdata   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && mem_en) begin
        req_addr <= mar;
        req_data <= mdr;
        req_we   <= mem_we;
        lat_cnt  <= 4'(LATENCY - 1);
      end else if (state == WAIT && lat_cnt != 4'd0) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      rdata <= (state_nx == RESP) ? rd_val : '0;
    end
  end

  // Backing RAM: contents survive reset, but a write still pending at reset is lost.
  always_ff @(posedge clk) begin
    if (rst_n && commit && req_we && req_in_ram) ram[req_addr[AW-1:0]] <= req_data;
  end

  // Keyboard, display and machine-control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kb_ready   <= 1'b0;
      kb_data    <= '0;
      dsr_ready  <= 1'b1;
      busy_cnt   <= '0;
      mcr_run    <= 1'b1;
      disp_valid <= 1'b0;
      disp_char  <= '0;
    end else begin
      disp_valid <= 1'b0;
      if (busy_cnt != '0) begin
        busy_cnt <= busy_cnt - 1'b1;
        if (busy_cnt == BW'(1)) dsr_ready <= 1'b1;
      end
      if (commit && req_we && req_addr == A_DDR && dsr_ready) begin
        disp_char  <= req_data[7:0];
        disp_valid <= 1'b1;
        dsr_ready  <= 1'b0;
        busy_cnt   <= BW'(DISP_BUSY);
      end
      if (commit && req_we && req_addr == A_MCR) mcr_run <= req_data[15];
      // A new keystroke arriving as KBDR is consumed wins over the clear.
      if (kbdr_clr) kb_ready <= 1'b0;
      if (kb_valid && (!kb_ready || kbdr_clr)) begin
        kb_ready <= 1'b1;
        kb_data  <= kb_char;
      end
    end
  end
endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder: directed steps then random traffic, all
// checked against a transaction-level model of RAM and device registers.
module tb_lc3_mem_responder;
  localparam int LATENCY   = 2;
  localparam int DISP_BUSY = 4;

  logic        clk = 1'b0;
  logic        rst_n, mem_en, mem_we, kb_valid;
  logic [15:0] mar, mdr, rdata;
  logic [7:0]  kb_char, disp_char;
  logic        mem_r, disp_valid, halted;

  lc3_mem_responder #(.MEM_WORDS(65536), .LATENCY(LATENCY), .DISP_BUSY(DISP_BUSY)) dut (
    .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .mem_we(mem_we), .mar(mar), .mdr(mdr),
    .rdata(rdata), .mem_r(mem_r), .kb_valid(kb_valid), .kb_char(kb_char),
    .disp_valid(disp_valid), .disp_char(disp_char), .halted(halted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;

  // model state
  logic [15:0] ram_m [int];
  logic        kb_rdy_m = 1'b0;
  logic [7:0]  kb_dat_m = 8'h00;
  logic        mcr_m    = 1'b1;
  logic [7:0]  dchar_m  = 8'h00;
  int          dcommit  = -100;

  function automatic bit dsr_rdy(input int c);
    return !(c >= dcommit && c < dcommit + DISP_BUSY);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus transaction; scrambles mar/mdr while waiting, returns R-cycle data.
  task automatic req(input logic we, input logic [15:0] a, input logic [15:0] d,
                     input logic kb_at, input logic [7:0] kc,
                     output logic [15:0] rd, output int rcyc, output logic dv);
    int n;
    logic seen;
    rd = 'x; rcyc = 0; n = 0; seen = 1'b0;
    @(negedge clk);
    mem_en = 1'b1; mem_we = we; mar = a; mdr = d;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      mar = 16'($urandom); mdr = 16'($urandom);
      if (mem_r) begin seen = 1'b1; rd = rdata; rcyc = cyc; end
    end
    chk($sformatf("latency@%h", a), 16'(n), 16'(LATENCY));
    mem_en = 1'b0;
    if (kb_at) begin kb_valid = 1'b1; kb_char = kc; end
    @(negedge clk);
    kb_valid = 1'b0;
    chk($sformatf("single_r@%h", a), {15'b0, mem_r}, 16'h0);
    dv = disp_valid;
  endtask

  task automatic op(input logic we, input logic [15:0] a, input logic [15:0] d,
                    input logic kb_at, input logic [7:0] kc);
    logic [15:0] rd, exp;
    int rc;
    logic dv, exp_dv;
    req(we, a, d, kb_at, kc, rd, rc, dv);
    exp_dv = 1'b0;
    if (!we) begin
      case (a)
        16'hFE00: exp = {kb_rdy_m, 15'b0};
        16'hFE02: exp = {8'h00, kb_dat_m};
        16'hFE04: exp = {dsr_rdy(rc - 1), 15'b0};
        16'hFE06: exp = 16'h0000;
        16'hFFFE: exp = {mcr_m, 15'b0};
        default:  exp = ram_m[int'(a)];
      endcase
      chk($sformatf("rdata@%h", a), rd, exp);
      if (a == 16'hFE02) kb_rdy_m = 1'b0;
    end else begin
      case (a)
        16'hFE06: if (dsr_rdy(rc)) begin dchar_m = d[7:0]; exp_dv = 1'b1; dcommit = rc + 1; end
        16'hFFFE: mcr_m = d[15];
        16'hFE00, 16'hFE02, 16'hFE04: ;
        default:  ram_m[int'(a)] = d;
      endcase
    end
    if (kb_at && !kb_rdy_m) begin kb_rdy_m = 1'b1; kb_dat_m = kc; end
    chk($sformatf("disp_valid@%h", a), {15'b0, dv}, {15'b0, exp_dv});
    chk("disp_char", {8'h00, disp_char}, {8'h00, dchar_m});
    chk("halted", {15'b0, halted}, {15'b0, ~mcr_m});
  endtask

  task automatic kb_pulse(input logic [7:0] c);
    @(negedge clk);
    kb_valid = 1'b1; kb_char = c;
    @(negedge clk);
    kb_valid = 1'b0;
    if (!kb_rdy_m) begin kb_rdy_m = 1'b1; kb_dat_m = c; end
  endtask

  initial begin
    logic seen_r;
    rst_n = 1'b0; mem_en = 1'b0; mem_we = 1'b0; mar = '0; mdr = '0;
    kb_valid = 1'b0; kb_char = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_r", {15'b0, mem_r}, 16'h0);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_disp_valid", {15'b0, disp_valid}, 16'h0);
    chk("rst_disp_char", {8'h00, disp_char}, 16'h0);
    chk("rst_halted", {15'b0, halted}, 16'h0);
    rst_n = 1'b1;

    // basic RAM read/write
    op(1, 16'h3000, 16'h1234, 0, 0);
    op(0, 16'h3000, 0, 0, 0);
    op(1, 16'h0005, 16'hBEEF, 0, 0);
    op(0, 16'h0005, 0, 0, 0);

    // keyboard
    op(0, 16'hFE00, 0, 0, 0);
    kb_pulse(8'h41);
    op(0, 16'hFE00, 0, 0, 0);
    op(0, 16'hFE02, 0, 0, 0);
    op(0, 16'hFE00, 0, 0, 0);
    kb_pulse(8'h41);
    kb_pulse(8'h42);
    op(0, 16'hFE02, 0, 0, 0);
    kb_pulse(8'h55);
    op(0, 16'hFE02, 0, 1, 8'h66);
    op(0, 16'hFE00, 0, 0, 0);
    op(0, 16'hFE02, 0, 0, 0);

    // display
    op(0, 16'hFE04, 0, 0, 0);
    op(1, 16'hFE06, 16'h0048, 0, 0);
    op(0, 16'hFE04, 0, 0, 0);
    op(0, 16'hFE04, 0, 0, 0);
    op(1, 16'hFE06, 16'h0050, 0, 0);
    op(1, 16'hFE06, 16'h0051, 0, 0);
    op(0, 16'hFE06, 0, 0, 0);

    // machine control
    op(1, 16'hFFFE, 16'h7FFF, 0, 0);
    op(0, 16'hFFFE, 0, 0, 0);
    op(1, 16'hFFFE, 16'h8000, 0, 0);
    op(0, 16'hFFFE, 0, 0, 0);

    // reset in the middle of a write
    op(1, 16'h0010, 16'h0001, 0, 0);
    kb_pulse(8'h77);
    op(1, 16'hFE06, 16'h0033, 0, 0);
    @(negedge clk);
    mem_en = 1'b1; mem_we = 1'b1; mar = 16'h0010; mdr = 16'hAAAA;
    @(negedge clk);
    rst_n = 1'b0; mem_en = 1'b0;
    seen_r = mem_r;
    repeat (2) begin @(negedge clk); seen_r |= mem_r; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); seen_r |= mem_r; end
    chk("rst_abandon_r", {15'b0, seen_r}, 16'h0);
    kb_rdy_m = 1'b0; kb_dat_m = 8'h00; mcr_m = 1'b1; dchar_m = 8'h00; dcommit = -100;
    chk("rst_mid_disp_char", {8'h00, disp_char}, 16'h0);
    op(0, 16'hFE04, 0, 0, 0);
    op(0, 16'hFE00, 0, 0, 0);
    op(0, 16'h0010, 0, 0, 0);

    // random traffic over a small RAM pool and the device registers
    for (int i = 0; i < 16; i++) op(1, 16'h3000 + 16'(i), 16'($urandom), 0, 0);
    for (int i = 0; i < 80; i++) begin
      logic [15:0] pa;
      pa = 16'h3000 + 16'($urandom_range(0, 15));
      case ($urandom_range(0, 11))
        0, 1:    op(1, pa, 16'($urandom), 0, 0);
        2, 3:    op(0, pa, 0, 0, 0);
        4:       op(0, 16'hFE00, 0, 0, 0);
        5:       op(0, 16'hFE02, 0, 1'($urandom_range(0, 1)), 8'($urandom));
        6:       op(0, 16'hFE04, 0, 0, 0);
        7:       op(1, 16'hFE06, 16'($urandom), 0, 0);
        8:       op(1, 16'hFFFE, 16'($urandom), 0, 0);
        9:       kb_pulse(8'($urandom));
        10:      op(0, 16'hFE06, 0, 0, 0);
        default: op(0, 16'hFFFE, 0, 0, 0);
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
